// File: rtl/event_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : event_capture_pkg
// Description : Shared types and helpers for the four-input event capture
//               front-end. It defines the change-record layout, the record and
//               drop-counter widths, and the (a|b)&(c|d) function.
// Revision    : 1.0 - initial release
// ============================================================================
package event_capture_pkg;

    localparam int EVT_W      = 9;
    localparam int DROP_CNT_W = 8;

    // Bit order in chg/val is {d,c,b,a}, so a is bit 0.
    typedef struct packed {
        logic       func;
        logic [3:0] chg;
        logic [3:0] val;
    } evt_t;

    function automatic logic evt_func(input logic [3:0] x);
        return (x[0] | x[1]) & (x[2] | x[3]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : event_fifo
// Description : Synchronous show-ahead FIFO of change records.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               push, i_wdata  - write request and record
//               pop            - consume head (ignored when empty)
//               o_rdata        - head record, zero when empty
//               full, empty    - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module event_fifo
    import event_capture_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic push,
    input  wire logic pop,
    input  wire evt_t i_wdata,
    output evt_t      o_rdata,
    output logic      full,
    output logic      empty
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    // One extra wrap bit on each pointer separates full from empty.
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    evt_t              r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                   (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);

    // A pop frees the slot at the same edge, so a push into a full FIFO
    // is accepted when a pop accompanies it.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    // Head is forced to zero while empty so the output is clean after reset.
    assign o_rdata = empty ? '0 : r_mem[r_rd_ptr[c_ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/event_change_capture.sv
`default_nettype none
// ============================================================================
// Module      : event_change_capture
// Description : Synchronises a,b,c,d, detects any change on them (clocked
//               @(a,b,c,d)), registers (a|b)&(c|d) and queues one change
//               record per event toward a valid/ready consumer.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               a, b, c, d          - asynchronous level inputs
//               out_level           - registered (a|b)&(c|d)
//               evt_valid/evt_ready - record handshake
//               evt_data            - {func, chg[3:0], val[3:0]}
//               overflow, drop_cnt  - sticky drop flag, saturating drop count
// Revision    : 1.0 - initial release
// ============================================================================
module event_change_capture
    import event_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  a,
    input  wire logic                  b,
    input  wire logic                  c,
    input  wire logic                  d,
    output logic                       out_level,
    output logic                       evt_valid,
    input  wire logic                  evt_ready,
    output logic [EVT_W-1:0]           evt_data,
    output logic                       overflow,
    output logic [DROP_CNT_W-1:0]      drop_cnt
);

    localparam int                c_ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [c_ARM_W-1:0] c_ARM_MAX = c_ARM_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic [3:0]                  r_prev;
    logic [c_ARM_W-1:0]          r_arm_cnt;
    logic                        r_out_level;
    logic                        r_overflow;
    logic [DROP_CNT_W-1:0]       r_drop_cnt;

    logic [3:0] w_in;
    logic [3:0] w_cur;
    logic [3:0] w_chg;
    logic       w_armed;
    logic       w_event;
    logic       w_pop;
    logic       w_drop;
    logic       w_full;
    logic       w_empty;
    evt_t       w_rec;
    evt_t       w_head;

    assign w_in  = {d, c, b, a};
    assign w_cur = r_sync[SYNC_STAGES-1];
    assign w_chg = w_cur ^ r_prev;

    // The arm counter covers the time for post-reset input levels to flush
    // through the synchroniser and prev, so static-high inputs raise no event.
    assign w_armed = (r_arm_cnt == c_ARM_MAX);
    assign w_event = w_armed & (|w_chg);

    always_comb begin
        w_rec      = '0;
        w_rec.func = evt_func(w_cur);
        w_rec.chg  = w_chg;
        w_rec.val  = w_cur;
    end

    assign w_pop  = ~w_empty & evt_ready;
    assign w_drop = w_event & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_prev      <= '0;
            r_arm_cnt   <= '0;
            r_out_level <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], w_in};
            r_prev      <= w_cur;
            r_out_level <= evt_func(w_cur);
            if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_event),
        .pop     (evt_ready),
        .i_wdata (w_rec),
        .o_rdata (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign out_level = r_out_level;
    assign evt_valid = ~w_empty;
    assign evt_data  = w_head;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_event_change_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_change_capture
// Description : Directed self-checking bench for event_change_capture
//               (SYNC_STAGES=2, FIFO_DEPTH=4). Expected records are written
//               out by hand as {func, chg dcba, val dcba}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_change_capture;

    logic       clk;
    logic       rst_n;
    logic       a, b, c, d;
    logic       out_level;
    logic       evt_valid;
    logic       evt_ready;
    logic [8:0] evt_data;
    logic       overflow;
    logic [7:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    event_change_capture #(
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_level (out_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want $finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [3:0] v);
        {d, c, b, a} = v;
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
    endtask

    logic [3:0] ovf_in  [6];
    logic [8:0] ovf_exp [4];
    logic [3:0] full_in [5];
    logic [8:0] full_exp[5];

    initial begin
        ovf_in[0] = 4'b0000; ovf_in[1] = 4'b0001; ovf_in[2] = 4'b0011;
        ovf_in[3] = 4'b0111; ovf_in[4] = 4'b1111; ovf_in[5] = 4'b1110;
        ovf_exp[0] = 9'b0_1001_0000;
        ovf_exp[1] = 9'b0_0001_0001;
        ovf_exp[2] = 9'b0_0010_0011;
        ovf_exp[3] = 9'b1_0100_0111;

        full_in[0] = 4'b0110; full_in[1] = 4'b0100; full_in[2] = 4'b0101;
        full_in[3] = 4'b1101; full_in[4] = 4'b1100;
        full_exp[0] = 9'b1_1000_0110;
        full_exp[1] = 9'b0_0010_0100;
        full_exp[2] = 9'b1_0001_0101;
        full_exp[3] = 9'b1_1000_1101;
        full_exp[4] = 9'b0_0001_1100;

        // Reset with all inputs high.
        rst_n     = 1'b0;
        evt_ready = 1'b0;
        set_in(4'b1111);
        tick(3);
        chk("rst_out_level", 32'(out_level), 32'd0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt_data",  32'(evt_data),  32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);
        rst_n = 1'b1;
        tick(10);
        chk("static_high_no_event", 32'(evt_valid), 32'd0);
        chk("static_high_level",    32'(out_level), 32'd1);

        // All inputs fall together: one record, three-edge latency.
        set_in(4'b0000);
        tick(2);
        chk("fall_all_not_yet", 32'(evt_valid), 32'd0);
        tick(1);
        chk("fall_all_valid", 32'(evt_valid), 32'd1);
        chk("fall_all_data",  32'(evt_data),  32'(9'b0_1111_0000));
        pop_one();
        chk("fall_all_popped", 32'(evt_valid), 32'd0);

        // Single toggle of c.
        set_in(4'b0100);
        tick(2);
        chk("c_rise_not_yet", 32'(evt_valid), 32'd0);
        tick(1);
        chk("c_rise_valid", 32'(evt_valid), 32'd1);
        chk("c_rise_data",  32'(evt_data),  32'(9'b0_0100_0100));
        chk("c_rise_level", 32'(out_level), 32'd0);
        pop_one();

        // Back to zero, then a and d together.
        set_in(4'b0000);
        tick(3);
        chk("c_fall_data", 32'(evt_data), 32'(9'b0_0100_0000));
        pop_one();
        set_in(4'b1001);
        tick(3);
        chk("ad_valid", 32'(evt_valid), 32'd1);
        chk("ad_data",  32'(evt_data),  32'(9'b1_1001_1001));
        chk("ad_level", 32'(out_level), 32'd1);
        tick(2);
        chk("ad_hold_valid", 32'(evt_valid), 32'd1);
        chk("ad_hold_data",  32'(evt_data),  32'(9'b1_1001_1001));
        pop_one();
        tick(2);
        chk("ad_single_record", 32'(evt_valid), 32'd0);

        // Overflow: six events into a depth-4 queue with no consumer.
        for (int i = 0; i < 6; i++) begin
            set_in(ovf_in[i]);
            tick(2);
        end
        tick(2);
        chk("ovf_flag",  32'(overflow), 32'd1);
        chk("ovf_count", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_valid_%0d", i), 32'(evt_valid), 32'd1);
            chk($sformatf("ovf_rec_%0d", i),   32'(evt_data),  32'(ovf_exp[i]));
            pop_one();
        end
        chk("ovf_drained", 32'(evt_valid), 32'd0);

        // Full queue with a pop in the same cycle as a new push.
        for (int i = 0; i < 4; i++) begin
            set_in(full_in[i]);
            tick(2);
        end
        tick(2);
        chk("full_head", 32'(evt_data), 32'(full_exp[0]));
        set_in(full_in[4]);
        tick(2);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        chk("full_pop_no_drop", 32'(drop_cnt), 32'd2);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("full_rec_%0d", i), 32'(evt_data), 32'(full_exp[i]));
            pop_one();
        end
        chk("full_drained", 32'(evt_valid), 32'd0);

        // Reset with three records queued.
        set_in(4'b1101);
        tick(2);
        set_in(4'b1111);
        tick(2);
        set_in(4'b0111);
        tick(4);
        chk("mid_queue_valid",    32'(evt_valid), 32'd1);
        chk("mid_queue_overflow", 32'(overflow),  32'd1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_valid",    32'(evt_valid), 32'd0);
        chk("async_rst_overflow", 32'(overflow),  32'd0);
        chk("async_rst_drop_cnt", 32'(drop_cnt),  32'd0);
        chk("async_rst_data",     32'(evt_data),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(10);
        chk("post_rst_no_event", 32'(evt_valid), 32'd0);
        set_in(4'b0101);
        tick(3);
        chk("rearmed_valid", 32'(evt_valid), 32'd1);
        chk("rearmed_data",  32'(evt_data),  32'(9'b1_0010_0101));
        chk("rearmed_level", 32'(out_level), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
